// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC model: FSM encoding and helpers
// used by both the controller and the sample accumulator bank.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Channels start evenly spread across the sample range so each one is distinguishable.
  function automatic int acc_init(input int c, input int data_w, input int num_ch);
    longint span;
    span = (longint'(1) << data_w) / longint'(num_ch);
    return int'(longint'(c) * span);
  endfunction

endpackage

// File: rtl/adc_sample_src.sv
// Per-channel sample accumulators: each channel steps by STEP after every
// completed conversion on that channel and is read combinationally by channel.
module adc_sample_src
  import adc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  parameter  int STEP   = 1,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [CH_W-1:0]   ch,
  output logic [DATA_W-1:0] sample
);

  logic [DATA_W-1:0] acc [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= DATA_W'(acc_init(c, DATA_W, NUM_CH));
      end
    end else if (inc) begin
      acc[ch] <= acc[ch] + DATA_W'(STEP);
    end
  end

  assign sample = acc[ch];

endmodule

// File: rtl/adc_multi_ch.sv
// Multi-channel ADC controller: accepts single or scan requests, waits the
// conversion time, then emits a one-cycle rdy with the sample and channel tag.
module adc_multi_ch
  import adc_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int NUM_CH      = 4,
  parameter  int CONV_CYCLES = 4,
  parameter  int STEP        = 1,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              scan_en,
  output logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic [CH_W-1:0]   dat_ch,
  output logic              busy,
  output logic              ovr
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic              scan, scan_n;
  logic              rdy_n;
  logic [DATA_W-1:0] dat_n;
  logic [CH_W-1:0]   dat_ch_n;
  logic              ovr_n;
  logic              accept;
  logic              inc;
  logic [DATA_W-1:0] sample;
  logic [CH_W-1:0]   sel_ch;

  adc_sample_src #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .STEP   (STEP)
  ) u_src (
    .clk    (clk),
    .rst    (rst),
    .inc    (inc),
    .ch     (ch),
    .sample (sample)
  );

  // Out-of-range channel selects clamp to the highest channel.
  assign sel_ch = (int'(ch_sel) > NUM_CH - 1) ? LAST_CH : ch_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ch     <= '0;
      scan   <= 1'b0;
      rdy    <= 1'b0;
      dat    <= '0;
      dat_ch <= '0;
      busy   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ch     <= ch_n;
      scan   <= scan_n;
      rdy    <= rdy_n;
      dat    <= dat_n;
      dat_ch <= dat_ch_n;
      busy   <= (state_n == CONV);
      ovr    <= ovr_n;
    end
  end

  // A request is taken from IDLE or from DONE once no scan step remains;
  // any request arriving while a conversion sequence is committed only sets ovr.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ch_n     = ch;
    scan_n   = scan;
    rdy_n    = 1'b0;
    dat_n    = dat;
    dat_ch_n = dat_ch;
    ovr_n    = ovr;
    accept   = 1'b0;
    inc      = 1'b0;

    case (state)
      IDLE: begin
        if (req) accept = 1'b1;
      end
      CONV: begin
        if (req) ovr_n = 1'b1;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n  = DONE;
          dat_n    = sample;
          dat_ch_n = ch;
          rdy_n    = 1'b1;
          inc      = 1'b1;
        end
      end
      DONE: begin
        if (scan && (ch < LAST_CH)) begin
          state_n = CONV;
          ch_n    = ch + 1'b1;
          cnt_n   = CNT_LOAD;
          if (req) ovr_n = 1'b1;
        end else if (req) begin
          accept = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      state_n = CONV;
      ch_n    = scan_en ? '0 : sel_ch;
      scan_n  = scan_en;
      cnt_n   = CNT_LOAD;
    end
  end

endmodule

// File: tb/tb_adc_multi_ch.sv
// Self-checking bench for adc_multi_ch: a schedule-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_adc_multi_ch;

  localparam int DATA_W      = 8;
  localparam int NUM_CH      = 4;
  localparam int CONV_CYCLES = 4;
  localparam int STEP        = 1;
  localparam int CH_W        = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [CH_W-1:0]   ch_sel;
  logic              scan_en;
  logic              rdy;
  logic [DATA_W-1:0] dat;
  logic [CH_W-1:0]   dat_ch;
  logic              busy;
  logic              ovr;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  adc_multi_ch #(
    .DATA_W      (DATA_W),
    .NUM_CH      (NUM_CH),
    .CONV_CYCLES (CONV_CYCLES),
    .STEP        (STEP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ch_sel  (ch_sel),
    .scan_en (scan_en),
    .rdy     (rdy),
    .dat     (dat),
    .dat_ch  (dat_ch),
    .busy    (busy),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: an accepted request becomes a list of future rdy edges;
  // outputs follow from that schedule and the per-channel sample values.
  typedef struct { int at; int ch; } conv_t;
  conv_t q[$];
  int    acc_m [NUM_CH];
  int    edge_n    = 0;
  int    free_edge = 0;
  bit    m_rdy, m_busy, m_ovr;
  int    m_dat, m_ch;

  always @(posedge clk) begin
    conv_t e;
    edge_n++;
    if (rst) begin
      q.delete();
      for (int c = 0; c < NUM_CH; c++) acc_m[c] = c * (256 / NUM_CH);
      m_rdy = 0; m_busy = 0; m_ovr = 0; m_dat = 0; m_ch = 0;
      free_edge = edge_n + 1;
    end else begin
      m_rdy = 0;
      if (q.size() > 0 && q[0].at == edge_n) begin
        e = q.pop_front();
        m_rdy = 1;
        m_dat = acc_m[e.ch];
        m_ch  = e.ch;
        acc_m[e.ch] = (acc_m[e.ch] + STEP) % 256;
      end
      if (req) begin
        if (edge_n >= free_edge) begin
          if (scan_en) begin
            for (int k = 0; k < NUM_CH; k++)
              q.push_back('{at: edge_n + CONV_CYCLES + k * (CONV_CYCLES + 1), ch: k});
          end else begin
            q.push_back('{at: edge_n + CONV_CYCLES,
                          ch: (int'(ch_sel) > NUM_CH - 1) ? NUM_CH - 1 : int'(ch_sel)});
          end
          free_edge = q[$].at + 1;
        end else begin
          m_ovr = 1;
        end
      end
      m_busy = (q.size() != 0) && !m_rdy;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model_rdy",  int'(rdy),  int'(m_rdy));
      check_output("model_busy", int'(busy), int'(m_busy));
      check_output("model_ovr",  int'(ovr),  int'(m_ovr));
      check_output("model_dat",  int'(dat),  m_dat);
      check_output("model_ch",   int'(dat_ch), m_ch);
    end
  end

  // Pulses req for exactly one edge; returns 1 time unit after that edge.
  task automatic apply_stimulus(input int cs, input bit sc);
    req     = 1'b1;
    ch_sel  = CH_W'(cs);
    scan_en = sc;
    @(posedge clk);
    #1;
    req     = 1'b0;
    ch_sel  = '0;
    scan_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts edges until rdy is seen; lat = -1 on timeout.
  task automatic wait_rdy(output int lat, output int d, output int c);
    lat = -1; d = -1; c = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = i; d = int'(dat); c = int'(dat_ch);
        return;
      end
    end
    check_output("rdy_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  lat, d, c;
    bit  seen;
    rst = 1'b1; req = 1'b0; ch_sel = '0; scan_en = 1'b0;

    // Reset state
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset_rdy",  int'(rdy), 0);
    check_output("reset_dat",  int'(dat), 0);
    check_output("reset_ch",   int'(dat_ch), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_ovr",  int'(ovr), 0);

    // Single conversion on ch2, then a back-to-back repeat taken from DONE
    apply_stimulus(2, 0);
    check_output("single_busy", int'(busy), 1);
    wait_rdy(lat, d, c);
    check_output("single_lat", lat, 4);
    check_output("single_dat", d, 128);
    check_output("single_ch",  c, 2);
    apply_stimulus(2, 0);
    wait_rdy(lat, d, c);
    check_output("repeat_lat", lat, 4);
    check_output("repeat_dat", d, 129);

    // Full scan from fresh accumulators
    do_reset(1);
    apply_stimulus(1, 1);
    for (int k = 0; k < NUM_CH; k++) begin
      wait_rdy(lat, d, c);
      check_output("scan_lat", lat, (k == 0) ? 4 : 5);
      check_output("scan_dat", d, k * 64);
      check_output("scan_ch",  c, k);
    end
    @(posedge clk);
    #1;
    check_output("scan_end_busy", int'(busy), 0);

    // Overrun during CONV, then a request accepted in DONE
    do_reset(1);
    apply_stimulus(1, 0);
    @(posedge clk);
    #1;
    apply_stimulus(3, 0);
    check_output("ovr_set", int'(ovr), 1);
    wait_rdy(lat, d, c);
    check_output("ovr_lat", lat, 2);
    check_output("ovr_dat", d, 64);
    check_output("ovr_ch",  c, 1);
    apply_stimulus(0, 0);
    wait_rdy(lat, d, c);
    check_output("done_accept_gap", lat + 1, 5);
    check_output("done_accept_ch",  c, 0);
    repeat (6) @(posedge clk);
    #1;
    check_output("ovr_sticky", int'(ovr), 1);
    do_reset(1);
    check_output("ovr_cleared", int'(ovr), 0);

    // Wrap of channel 3 after 64 conversions
    for (int i = 0; i < 65; i++) begin
      apply_stimulus(3, 0);
      wait_rdy(lat, d, c);
      if (i == 0)  check_output("wrap_first", d, 192);
      if (i == 63) check_output("wrap_last",  d, 255);
      if (i == 64) check_output("wrap_zero",  d, 0);
    end

    // Reset in the middle of a conversion aborts it
    do_reset(1);
    apply_stimulus(2, 0);
    @(posedge clk);
    #1;
    do_reset(1);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_dat",  int'(dat), 0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rdy) seen = 1'b1;
    end
    check_output("abort_no_rdy", int'(seen), 0);
    apply_stimulus(2, 0);
    wait_rdy(lat, d, c);
    check_output("abort_next_dat", d, 128);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
